// File: rtl/req_priority_encoder.sv
// req_priority_encoder
//
// Sequential N-to-W priority encoder with a valid/ack handshake.
//
// Rising edges on req are captured into sticky pending bits. When idle and
// enabled, the highest-index pending bit is presented as a binary code with
// valid held high until the consumer acks it. The acked request is cleared
// on that same edge. A new event on the acked bit in that cycle wins over
// the clear, so the bit stays pending.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   e        enable; gates issue of new codes only (events are still captured)
//   req      request lines (level); rising edges are events
//   ack      consumer accepts the presented code (ignored while valid=0)
//   code     index of the presented request
//   valid    code is valid and held stable
//   pending  sticky pending bits (registered)
//   ovf      one-cycle pulse: an event hit an already-pending bit and was merged
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing presented; issue highest pending code when e=1
// PRESENT | code presented with valid=1, frozen until ack

module req_priority_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         ovf
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   req_q;
    logic [N-1:0]   evt;
    logic [N-1:0]   clr;
    logic [W-1:0]   sel;
    logic [W-1:0]   code_nxt;

    assign evt   = req & ~req_q;
    assign valid = (state == PRESENT);

    // Clear only the bit whose code is being accepted right now.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = (state == PRESENT) && ack && (code == W'(i));
        end
    end

    // Ascending scan: the last hit is the highest index, i.e. highest priority.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                sel = W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        case (state)
            IDLE: begin
                if (e && (|pending)) begin
                    code_nxt  = sel;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            code    <= '0;
            req_q   <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            req_q   <= req;
            // Set wins over clear.
            pending <= evt | (pending & ~clr);
            ovf     <= |(evt & pending & ~clr);
        end
    end

endmodule
